seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//   Multi-cycle restoring divider for MIPS DIV/DIVU. Consumes the two register-file read
//   ports (RS = dividend, RT = divisor) and produces quotient (for LO) and remainder (for HI).
//   Sits beside the ALU in the execute stage. Controller stalls on busy; it writes HI/LO on done.
// PARAMETERS
//   WIDTH   32   operand/result width in bits (must be >= 2)
// PORTS
//   DIV_clk    in   1      single clock, rising edge
//   DIV_rst_n  in   1      asynchronous, active-low reset
//   start      in   1      request; sampled only in IDLE
//   sign       in   1      1 = DIV (two's complement), 0 = DIVU
//   dividend   in   WIDTH  RS operand, captured on accepted start
//   divisor    in   WIDTH  RT operand, captured on accepted start
//   busy       out  1      1 while an operation is in progress
//   done       out  1      one-cycle pulse: q/r/dbz valid
//   q          out  WIDTH  quotient (held until next accepted start)
//   r          out  WIDTH  remainder (held until next accepted start)
//   dbz        out  1      divide-by-zero flag for the last operation
// BEHAVIOUR
//   Reset (async assert, sync-to-clock deassert by upstream): state IDLE. busy, done and dbz
//     are 0. q, r and the counter are 0. A reset mid-operation aborts it and no done is issued.
//   States: IDLE -> CALC -> FIX -> IDLE. A divide by zero goes straight IDLE -> FIX.
//   IDLE: at the edge where start=1 (edge 0), latch operands and busy<=1.
//     sign=1: latch |dividend|, |divisor| and record neg_q = sign bits differ, neg_r = dividend sign.
//     sign=0: latch raw values, neg_q = neg_r = 0.
//     divisor==0: dbz<=1 and go to FIX. Otherwise dbz<=0, cnt<=WIDTH-1, go to CALC.
//   CALC: one restoring step per edge (edges 1..WIDTH).
//     Shift {rem,quo} left 1, trial-subtract the divisor from rem (WIDTH+1-bit subtract).
//     Non-negative result: keep it and set quo[0]=1. Otherwise restore.
//     cnt decrements; at cnt==0 go to FIX.
//   FIX (edge WIDTH+1; edge 1 for dbz): q <= neg_q ? -quo : quo, r <= neg_r ? -rem : rem.
//     Pulse done=1, busy<=0, return to IDLE.
//     dbz result: q = all-ones, r = dividend as presented (no sign fix).
//   Latency: done is high in the cycle after edge WIDTH+1 (33 for WIDTH=32). For dbz it is
//     high after edge 1. Throughput: one op per WIDTH+2 cycles.
//   start while busy: ignored, no queuing.
//   start in the done cycle: accepted (state is IDLE), so back-to-back ops are legal.
//   Operand inputs are don't-care except at the accepting edge.
//   Overflow: signed 0x8000_0000 / 0xFFFF_FFFF gives q=0x8000_0000, r=0 with no flag.
//     This falls out naturally from unsigned magnitude arithmetic plus negation.
//   All arithmetic is modulo 2^WIDTH. Negation is two's complement (~x+1).
// STRUCTURE
//   Package div_pkg: state enum {IDLE, CALC, FIX}, CNT_W = $clog2(WIDTH), DIV_WIDTH = 32.
//   One natural sub-module: div_step. Purely combinational, it does one shift/trial-subtract
//     iteration ({rem,quo},divisor -> {rem',quo'}) so it can be unit-tested and reused by a
//     future radix-4 variant. The FSM, counter and sign fix stay in seq_divider.
// TESTING
//   1 DIVU 100/7: start at t0 -> busy 1 from t0+1; done at t0+33, q=14, r=2, dbz=0.
//   2 DIV 0xFFFF_FFF9/2 (-7/2) -> q=0xFFFF_FFFD (-3), r=0xFFFF_FFFF (-1).
//     Then DIV 7/0xFFFF_FFFE -> q=-3, r=1.
//   3 DIV 0x8000_0000/0xFFFF_FFFF -> q=0x8000_0000, r=0, dbz=0.
//     DIVU 0xFFFF_FFFF/1 -> q=0xFFFF_FFFF, r=0.
//   4 DIVU 5/0 -> done one cycle after acceptance: dbz=1, q=0xFFFF_FFFF, r=5.
//     The next normal op clears dbz.
//   5 Start held high throughout: ops accepted only in IDLE/done cycles, one per 34 cycles.
//     Operand change while busy leaves the result unchanged.
//   6 Assert DIV_rst_n=0 at cycle 10 of an op -> busy, done, q, r, dbz go 0 immediately.
//     No done follows. A fresh op after release completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types and constants for the sequential MIPS divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division iteration (shift + trial subtract).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] w_part;
  logic [WIDTH:0] w_trial;

  // rem < dvs < 2^WIDTH, so the top bit of the WIDTH+1 result is a true sign bit.
  assign w_part  = {rem_in, quo_in[WIDTH-1]};
  assign w_trial = w_part - {1'b0, dvs};

  assign rem_out = w_trial[WIDTH] ? w_part[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Brief   : Multi-cycle restoring divider for MIPS DIV/DIVU (quotient->LO, remainder->HI).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             DIV_clk,
  input  logic             DIV_rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int               c_CNT_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(WIDTH-1);

  div_state_t         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;

  logic [WIDTH-1:0]   w_dd_mag;
  logic [WIDTH-1:0]   w_dv_mag;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  assign w_dd_mag = (sign && dividend[WIDTH-1]) ? (~dividend + c_ONE) : dividend;
  assign w_dv_mag = (sign && divisor[WIDTH-1])  ? (~divisor + c_ONE)  : divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .dvs     (r_dvs),
    .rem_out (w_rem_nxt),
    .quo_out (w_quo_nxt)
  );

  always_ff @(posedge DIV_clk or negedge DIV_rst_n) begin
    if (!DIV_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_rem   <= '0;
            r_dvs   <= w_dv_mag;
            r_neg_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= sign & dividend[WIDTH-1];
            if (divisor == '0) begin
              // Raw dividend is parked in r_quo so FIX can return it unmodified in r.
              dbz     <= 1'b1;
              r_quo   <= dividend;
              r_state <= FIX;
            end else begin
              dbz     <= 1'b0;
              r_quo   <= w_dd_mag;
              r_cnt   <= c_CNT_TOP;
              r_state <= CALC;
            end
          end
        end

        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          if (dbz) begin
            q <= '1;
            r <= r_quo;
          end else begin
            q <= r_neg_q ? (~r_quo + c_ONE) : r_quo;
            r <= r_neg_r ? (~r_rem + c_ONE) : r_rem;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
